olivia_imem_loader: RTL and testbench
=====================================

Name: olivia_imem_loader

Overview:
- Boot-time program loader directly upstream of the Olivia core.
- Accepts 32-bit instruction words over a valid/ready stream and writes them byte-wise, big-endian, into the core's byte-addressed instruction memory.
- Zero-fills the unused tail of instruction memory so that it reads as NOP.
- Holds the core in reset until loading completes, then releases it. A reload pulse restarts the whole sequence.

Parameters:
- IMEM_BYTES, 64, instruction memory size in bytes; must be a multiple of 4 (16 words by default).
- ADDR_W, 6, width of im_addr; must satisfy 2**ADDR_W >= IMEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  instruction word.
- s_last  in  1  marks the final word of the program; qualified by s_valid & s_ready.
- reload  in  1  single-cycle pulse: restart loading; ignored unless in RUN.
- im_we  out  1  instruction memory byte write enable.
- im_addr  out  ADDR_W  byte address.
- im_wdata  out  8  byte write data.
- core_rst  out  1  active-high reset to the core (the core's rst input).
- done  out  1  program loaded, core running.
- err_overflow  out  1  program exceeded IMEM_BYTES (no s_last at the final slot).

Behaviour:
- Every output is registered (Moore-style); it changes on the edge that enters a state.
- Reset (rst==0 at an edge):
  - State goes to RECV; base=0, beat=0.
  - s_ready=0, im_we=0, im_addr=0, im_wdata=0, core_rst=1, done=0, err_overflow=0.
  - Reset applies in any state, including mid-WRITE or mid-ZFILL; no partial write is completed.
- States:
  - RECV:
    - s_ready=1, im_we=0.
    - On s_valid & s_ready: capture s_data and s_last; next state WRITE with beat=0.
    - Without s_valid: stay in RECV; no writes.
  - WRITE, 4 cycles:
    - im_we=1, im_addr=base+beat, im_wdata=word[31-8*beat -: 8] (MSB at the lowest address), s_ready=0.
    - After beat 3, base += 4, then:
      - If the captured last bit is set and base < IMEM_BYTES: go to ZFILL.
      - If the captured last bit is set and base == IMEM_BYTES: go to RELEASE.
      - If the captured last bit is clear and base == IMEM_BYTES: set err_overflow=1 (sticky) and go to RELEASE.
      - Otherwise: go to RECV.
  - ZFILL:
    - im_we=1, im_wdata=0, im_addr increments by 1 per cycle from base up to IMEM_BYTES-1.
    - Then go to RELEASE.
  - RELEASE, 1 cycle: im_we=0, core_rst still 1, so the core sees at least one clean reset cycle after the final write.
  - RUN:
    - core_rst=0, done=1, s_ready=0.
    - reload==1 causes the next cycle to be RECV with core_rst=1, done=0, err_overflow=0, base=0.
- Timing:
  - Latency: a word accepted at edge N is written at edges N+1..N+4; s_ready returns high at N+5.
  - Throughput: 1 word per 5 cycles.
- Boundary conditions:
  - s_valid while s_ready=0 is not consumed; upstream must hold it.
  - Words offered in RUN or after overflow are never accepted.
  - reload in any state other than RUN is ignored.
  - im_addr wraps never: it is bounded by IMEM_BYTES-1.
  - A single-word program (s_last on the first word) is valid.

Decomposition:
- Package olivia_pkg holds:
  - State enum: RECV, WRITE, ZFILL, RELEASE, RUN.
  - NOP_WORD = 32'h0.
  - Default IMEM_BYTES.
- No sub-module. The byte-serialiser is a 2-bit beat counter plus a mux inside the FSM.

Test Plan:
- Three words 8B0203E1, CB0203E2, F84083E3 (s_last on the third):
  - Bytes 0..11 equal 8B,02,03,E1,CB,02,03,E2,F8,40,83,E3.
  - Bytes 12..63 equal 0, written over exactly 52 ZFILL cycles.
  - core_rst falls one cycle after the last ZFILL write; done=1; err_overflow=0.
- Sixteen words, s_last on the 16th:
  - No ZFILL cycles; RELEASE directly after the 64th byte write.
  - done=1; err_overflow=0; 80 cycles from first accept to RELEASE.
- Seventeen words offered without s_last at word 16:
  - err_overflow=1 after byte 63 is written.
  - The 17th word is never accepted (s_ready stays 0).
  - core_rst is released; done=1.
- Backpressure: s_valid deasserted 7 cycles between words:
  - im_we=0 throughout each gap.
  - Each word is still written at accept+1..+4.
  - Memory image identical to the gap-free run.
- reload pulse in RUN after the first scenario:
  - Next cycle: core_rst=1, done=0, s_ready=1.
  - A new 1-word program, 00000000 with s_last, zero-fills bytes 4..63 and completes.
- rst=0 asserted during WRITE beat 2:
  - Next edge: im_we=0, core_rst=1, s_ready=0.
  - One cycle after rst returns high: s_ready=1, base=0.

Source files
------------

// File: rtl/olivia_imem_loader_pkg.sv
// Shared types and constants for the Olivia instruction-memory loader.
package olivia_pkg;

  typedef enum logic [2:0] {
    RECV,
    WRITE,
    ZFILL,
    RELEASE,
    RUN
  } state_t;

  localparam logic [31:0] NOP_WORD           = 32'h0;
  localparam int          DEFAULT_IMEM_BYTES = 64;

endpackage

// File: rtl/olivia_imem_loader.sv
// Boot loader: streams 32-bit words big-endian into byte-wide instruction memory,
// zero-fills the unused tail, then releases the core from reset.
module olivia_imem_loader
  import olivia_pkg::*;
#(
  parameter int IMEM_BYTES = DEFAULT_IMEM_BYTES,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err_overflow
);

  // One extra bit so the base pointer can hold IMEM_BYTES itself.
  localparam int                BASE_W    = ADDR_W + 1;
  localparam logic [BASE_W-1:0] IMEM_END  = BASE_W'(IMEM_BYTES);
  localparam logic [BASE_W-1:0] IMEM_LAST = BASE_W'(IMEM_BYTES - 1);

  state_t            r_state, w_state;
  logic [BASE_W-1:0] r_base, w_base;
  logic [1:0]        r_beat, w_beat;
  logic [31:0]       r_word, w_word;
  logic              r_last, w_last;
  logic              r_err, w_err;

  logic              r_s_ready, w_s_ready;
  logic              r_im_we, w_im_we;
  logic [ADDR_W-1:0] r_im_addr, w_im_addr;
  logic [7:0]        r_im_wdata, w_im_wdata;
  logic              r_core_rst, w_core_rst;
  logic              r_done, w_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RECV;
      r_base     <= '0;
      r_beat     <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_s_ready  <= 1'b0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_base     <= w_base;
      r_beat     <= w_beat;
      r_word     <= w_word;
      r_last     <= w_last;
      r_err      <= w_err;
      r_s_ready  <= w_s_ready;
      r_im_we    <= w_im_we;
      r_im_addr  <= w_im_addr;
      r_im_wdata <= w_im_wdata;
      r_core_rst <= w_core_rst;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_base  = r_base;
    w_beat  = r_beat;
    w_word  = r_word;
    w_last  = r_last;
    w_err   = r_err;
    case (r_state)
      RECV: begin
        if (s_valid && r_s_ready) begin
          w_word  = s_data;
          w_last  = s_last;
          w_beat  = 2'd0;
          w_state = WRITE;
        end
      end
      WRITE: begin
        if (r_beat != 2'd3) begin
          w_beat = r_beat + 2'd1;
        end else begin
          w_base = r_base + BASE_W'(4);
          if (r_last && (w_base < IMEM_END)) begin
            w_state = ZFILL;
          end else if (w_base == IMEM_END) begin
            w_err   = r_err | ~r_last;
            w_state = RELEASE;
          end else begin
            w_state = RECV;
          end
        end
      end
      ZFILL: begin
        if (r_base == IMEM_LAST) w_state = RELEASE;
        else                     w_base  = r_base + BASE_W'(1);
      end
      RELEASE: w_state = RUN;
      RUN: begin
        if (reload) begin
          w_state = RECV;
          w_base  = '0;
          w_beat  = 2'd0;
          w_err   = 1'b0;
        end
      end
      default: w_state = RECV;
    endcase
  end

  // Outputs are computed from the upcoming state so they register on the entering edge.
  always_comb begin
    w_s_ready  = (w_state == RECV);
    w_im_we    = (w_state == WRITE) || (w_state == ZFILL);
    w_core_rst = (w_state != RUN);
    w_done     = (w_state == RUN);
    w_im_addr  = '0;
    w_im_wdata = '0;
    if (w_state == WRITE) begin
      w_im_addr = w_base[ADDR_W-1:0] + ADDR_W'(w_beat);
      case (w_beat)
        2'd0:    w_im_wdata = w_word[31:24];
        2'd1:    w_im_wdata = w_word[23:16];
        2'd2:    w_im_wdata = w_word[15:8];
        default: w_im_wdata = w_word[7:0];
      endcase
    end else if (w_state == ZFILL) begin
      w_im_addr  = w_base[ADDR_W-1:0];
      w_im_wdata = NOP_WORD[7:0];
    end
  end

  assign s_ready      = r_s_ready;
  assign im_we        = r_im_we;
  assign im_addr      = r_im_addr;
  assign im_wdata     = r_im_wdata;
  assign core_rst     = r_core_rst;
  assign done         = r_done;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_olivia_imem_loader.sv
// Self-checking bench for olivia_imem_loader: directed programs checked against a byte memory model.
module tb_olivia_imem_loader;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  b0, b1, b2, b3;
  } wordVec_t;

  typedef struct {
    int         addr;
    logic [7:0] expByte;
  } memVec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        reload = 1'b0;
  logic        s_ready, im_we, core_rst, done, err_overflow;
  logic [5:0]  im_addr;
  logic [7:0]  im_wdata;

  int nChecks = 0;
  int nFails  = 0;

  wordVec_t prog3 [3];
  memVec_t  prog16Check [8];

  always #5 clk = ~clk;

  olivia_imem_loader #(.IMEM_BYTES(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .reload(reload),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_rst(core_rst), .done(done), .err_overflow(err_overflow)
  );

  // Byte memory model plus edge-stamped accept/write bookkeeping.
  logic [7:0] mem [64];
  int cyc = 0, writeCount = 0, acceptCount = 0, lastAcceptCyc = 0, lastWriteCyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid && s_ready) begin
      acceptCount   <= acceptCount + 1;
      lastAcceptCyc <= cyc;
    end
    if (im_we) begin
      mem[im_addr] <= im_wdata;
      writeCount   <= writeCount + 1;
      lastWriteCyc <= cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last, input int budget, output bit ok);
    int n = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (s_ready !== 1'b1 && n < budget) begin
      stepCycle();
      n++;
    end
    ok = (s_ready === 1'b1);
    if (ok) stepCycle();
    s_valid = 1'b0;
  endtask

  task automatic waitRun(output int weToRun, output bit ok);
    int n = 0;
    int lastWe = -100;
    while (core_rst !== 1'b0 && n < 300) begin
      if (im_we === 1'b1) lastWe = n;
      stepCycle();
      n++;
    end
    ok = (core_rst === 1'b0);
    weToRun = n - lastWe;
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    stepCycle();
    reload = 1'b0;
  endtask

  task automatic checkProg3();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("byte[%0d]", 4*i),   32'(mem[4*i]),   32'(prog3[i].b0));
      checkOutput($sformatf("byte[%0d]", 4*i+1), 32'(mem[4*i+1]), 32'(prog3[i].b1));
      checkOutput($sformatf("byte[%0d]", 4*i+2), 32'(mem[4*i+2]), 32'(prog3[i].b2));
      checkOutput($sformatf("byte[%0d]", 4*i+3), 32'(mem[4*i+3]), 32'(prog3[i].b3));
    end
  endtask

  task automatic checkZeroFrom(input int first);
    int bad = 0;
    for (int a = first; a < 64; a++) if (mem[a] !== 8'h00) bad++;
    checkOutput($sformatf("zeroTailFrom%0d", first), 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int weToRun, w0, a0, startCyc, wBefore, gapBad;

    prog3[0] = '{32'h8B0203E1, 1'b0, 8'h8B, 8'h02, 8'h03, 8'hE1};
    prog3[1] = '{32'hCB0203E2, 1'b0, 8'hCB, 8'h02, 8'h03, 8'hE2};
    prog3[2] = '{32'hF84083E3, 1'b1, 8'hF8, 8'h40, 8'h83, 8'hE3};
    prog16Check[0] = '{0,  8'hA0};
    prog16Check[1] = '{1,  8'hB0};
    prog16Check[2] = '{2,  8'hC0};
    prog16Check[3] = '{3,  8'hD0};
    prog16Check[4] = '{60, 8'hA0};
    prog16Check[5] = '{61, 8'hB0};
    prog16Check[6] = '{62, 8'hC0};
    prog16Check[7] = '{63, 8'hDF};

    // Reset state
    repeat (3) stepCycle();
    checkOutput("rstReady",    32'(s_ready),      32'd0);
    checkOutput("rstWe",       32'(im_we),        32'd0);
    checkOutput("rstAddr",     32'(im_addr),      32'd0);
    checkOutput("rstWdata",    32'(im_wdata),     32'd0);
    checkOutput("rstCoreRst",  32'(core_rst),     32'd1);
    checkOutput("rstDone",     32'(done),         32'd0);
    checkOutput("rstOverflow", 32'(err_overflow), 32'd0);
    rst = 1'b1;
    stepCycle();
    checkOutput("readyAfterRst", 32'(s_ready), 32'd1);

    // Three-word program with zero-filled tail
    w0 = writeCount;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(prog3[i].data, prog3[i].last, 20, ok);
      checkOutput("accept3", 32'(ok), 32'd1);
    end
    waitRun(weToRun, ok);
    checkOutput("run3",      32'(ok),           32'd1);
    checkOutput("writes3",   32'(writeCount - w0), 32'd64);
    // last write seen at poll k, RELEASE at k+1, core_rst low at k+2
    checkOutput("weToRun3",  32'(weToRun),      32'd2);
    checkOutput("done3",     32'(done),         32'd1);
    checkOutput("overflow3", 32'(err_overflow), 32'd0);
    checkProg3();
    checkZeroFrom(12);

    // Reload from RUN, then a single zero word
    pulseReload();
    checkOutput("reloadCoreRst", 32'(core_rst),     32'd1);
    checkOutput("reloadDone",    32'(done),         32'd0);
    checkOutput("reloadReady",   32'(s_ready),      32'd1);
    checkOutput("reloadOvf",     32'(err_overflow), 32'd0);
    pulseReload();
    checkOutput("reloadInRecv",  32'(s_ready),      32'd1);
    w0 = writeCount;
    applyStimulus(32'h0000_0000, 1'b1, 20, ok);
    checkOutput("accept1", 32'(ok), 32'd1);
    waitRun(weToRun, ok);
    checkOutput("run1",    32'(ok),              32'd1);
    checkOutput("writes1", 32'(writeCount - w0), 32'd64);
    checkOutput("done1",   32'(done),            32'd1);
    checkZeroFrom(0);

    // Sixteen words: no ZFILL, reload during WRITE must be ignored
    pulseReload();
    w0 = writeCount;
    startCyc = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'hA0B0C0D0 + 32'(i), (i == 15), 20, ok);
      checkOutput("accept16", 32'(ok), 32'd1);
      if (i == 0) begin
        startCyc = cyc;
        pulseReload();
        checkOutput("reloadInWriteWe",   32'(im_we),   32'd1);
        checkOutput("reloadInWriteAddr", 32'(im_addr), 32'd1);
      end
    end
    waitRun(weToRun, ok);
    checkOutput("run16",        32'(ok),                32'd1);
    checkOutput("acceptToRun",  32'(cyc - startCyc),    32'd80);
    checkOutput("writes16",     32'(writeCount - w0),   32'd64);
    checkOutput("weToRun16",    32'(weToRun),           32'd2);
    checkOutput("done16",       32'(done),              32'd1);
    checkOutput("overflow16",   32'(err_overflow),      32'd0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("img16[%0d]", prog16Check[i].addr),
                  32'(mem[prog16Check[i].addr]), 32'(prog16Check[i].expByte));

    // Overflow: sixteen words without s_last, then a rejected 17th
    pulseReload();
    w0 = writeCount;
    a0 = acceptCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'h11223300 + 32'(i), 1'b0, 20, ok);
      checkOutput("acceptOvf", 32'(ok), 32'd1);
    end
    waitRun(weToRun, ok);
    checkOutput("runOvf",      32'(ok),              32'd1);
    checkOutput("writesOvf",   32'(writeCount - w0), 32'd64);
    checkOutput("overflowSet", 32'(err_overflow),    32'd1);
    checkOutput("doneOvf",     32'(done),            32'd1);
    checkOutput("byte63Ovf",   32'(mem[63]),         32'h0F);
    applyStimulus(32'hDEADBEEF, 1'b1, 20, ok);
    checkOutput("word17Rejected", 32'(ok),               32'd0);
    checkOutput("acceptsOvf",     32'(acceptCount - a0), 32'd16);
    checkOutput("overflowSticky", 32'(err_overflow),     32'd1);

    // Backpressure: 7 idle cycles between words
    pulseReload();
    checkOutput("overflowCleared", 32'(err_overflow), 32'd0);
    w0 = writeCount;
    for (int i = 0; i < 3; i++) begin
      wBefore = writeCount;
      applyStimulus(prog3[i].data, prog3[i].last, 20, ok);
      checkOutput("acceptBp", 32'(ok), 32'd1);
      repeat (4) stepCycle();
      checkOutput("bpLatency",    32'(lastWriteCyc - lastAcceptCyc), 32'd4);
      checkOutput("bpWordWrites", 32'(writeCount - wBefore),         32'd4);
      if (i < 2) begin
        gapBad = 0;
        repeat (7) begin
          if (im_we !== 1'b0) gapBad++;
          stepCycle();
        end
        checkOutput("bpGapIdle", 32'(gapBad), 32'd0);
      end
    end
    waitRun(weToRun, ok);
    checkOutput("runBp",    32'(ok),              32'd1);
    checkOutput("writesBp", 32'(writeCount - w0), 32'd64);
    checkProg3();
    checkZeroFrom(12);

    // Reset asserted while WRITE beat 2 is on the bus
    pulseReload();
    applyStimulus(32'h12345678, 1'b1, 20, ok);
    checkOutput("acceptRst", 32'(ok), 32'd1);
    repeat (2) stepCycle();
    checkOutput("beat2Addr", 32'(im_addr), 32'd2);
    rst = 1'b0;
    stepCycle();
    checkOutput("midRstWe",      32'(im_we),    32'd0);
    checkOutput("midRstCoreRst", 32'(core_rst), 32'd1);
    checkOutput("midRstReady",   32'(s_ready),  32'd0);
    checkOutput("midRstDone",    32'(done),     32'd0);
    rst = 1'b1;
    stepCycle();
    checkOutput("postRstReady", 32'(s_ready), 32'd1);
    applyStimulus(32'hCAFEF00D, 1'b1, 20, ok);
    checkOutput("acceptAfterRst", 32'(ok),       32'd1);
    checkOutput("baseZeroAddr",   32'(im_addr),  32'd0);
    checkOutput("baseZeroData",   32'(im_wdata), 32'hCA);
    waitRun(weToRun, ok);
    checkOutput("runAfterRst", 32'(ok),      32'd1);
    checkOutput("imgRst0",     32'(mem[0]),  32'hCA);
    checkOutput("imgRst3",     32'(mem[3]),  32'h0D);
    checkZeroFrom(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
